// File: rtl/reg_lock_scheduler.sv
// reg_lock_scheduler: register-lock scoreboard with a round-robin single-issue grant.
package rv64g_pkg;
  localparam int NUM_REGS = 32;
endpackage

module reg_lock_scheduler #(
  parameter int NUM_REQ = 4,
  localparam int NR = rv64g_pkg::NUM_REGS,
  localparam int RW = $clog2(NR),
  localparam int QW = $clog2(NUM_REQ)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  input  logic [NUM_REQ-1:0]    req_jump_i,
  input  logic [NUM_REQ*RW-1:0] req_rd_i,
  input  logic [NUM_REQ*NR-1:0] req_regs_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  output logic                  gnt_valid_o,
  output logic [QW-1:0]         gnt_idx_o,
  input  logic                  wb_valid_i,
  input  logic [RW-1:0]         wb_rd_i,
  input  logic                  flush_i,
  output logic [NR-1:0]         locks_o
);
  logic [NR-1:0] locks_q;
  logic [QW-1:0] rr_ptr_q;
  logic [NR-1:0] rd_mask [NUM_REQ];
  logic [NUM_REQ-1:0] elig;
  logic hit, gnt;
  logic [QW-1:0] idx;
  logic [NR-1:0] set_mask, clr_mask;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_req
    logic [RW-1:0] rd;
    assign rd = req_rd_i[k*RW +: RW];
    // x0 is hardwired zero, so it never takes a WAW lock
    assign rd_mask[k] = (rd == '0) ? '0 : NR'(1) << rd;
    assign elig[k] = req_valid_i[k] & ~|(locks_q & (req_regs_i[k*NR +: NR] | rd_mask[k]));
  end

  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int j;
      j = int'(rr_ptr_q) + i;
      j = (j >= NUM_REQ) ? j - NUM_REQ : j;
      if (!hit && elig[QW'(j)]) begin
        hit = 1'b1;
        idx = QW'(j);
      end
    end
  end

  assign gnt = hit & ~rst_i;
  assign set_mask = !gnt ? '0 : req_jump_i[idx] ? '1 : rd_mask[idx];
  assign clr_mask = wb_valid_i ? NR'(1) << wb_rd_i : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      locks_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      locks_q <= flush_i ? set_mask : (locks_q & ~clr_mask) | set_mask;
      if (gnt) rr_ptr_q <= (idx == QW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    end
  end

  assign req_ready_o = gnt ? NUM_REQ'(1) << idx : '0;
  assign gnt_valid_o = gnt;
  assign gnt_idx_o = gnt ? idx : '0;
  assign locks_o = locks_q;
endmodule

// File: tb/tb_reg_lock_scheduler.sv
// tb_reg_lock_scheduler: directed vector table plus randomized run against a lock/queue model.
module tb_reg_lock_scheduler;
  localparam int N = 4;
  localparam int NR = 32;
  localparam int RW = 5;
  localparam int QW = 2;

  logic clk = 0;
  logic rst;
  logic [N-1:0] valid, jump, ready;
  logic [N*RW-1:0] rd;
  logic [N*NR-1:0] regs;
  logic gvalid, wbv, fl;
  logic [QW-1:0] gidx;
  logic [RW-1:0] wbr;
  logic [NR-1:0] locks;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  reg_lock_scheduler #(.NUM_REQ(N)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_jump_i(jump), .req_rd_i(rd),
    .req_regs_i(regs), .req_ready_o(ready), .gnt_valid_o(gvalid), .gnt_idx_o(gidx),
    .wb_valid_i(wbv), .wb_rd_i(wbr), .flush_i(fl), .locks_o(locks)
  );

  typedef struct {
    logic r;
    logic [N-1:0] v, j;
    logic [N*RW-1:0] d;
    logic [N*NR-1:0] s;
    logic wv;
    logic [RW-1:0] wr;
    logic f;
    logic [N-1:0] e_ready;
    logic [NR-1:0] e_locks;
  } vec_t;

  function automatic vec_t mk(logic r, logic [N-1:0] v, j, logic [N*RW-1:0] d, logic [N*NR-1:0] s,
                              logic wv, logic [RW-1:0] wr, logic f, logic [N-1:0] er, logic [NR-1:0] el);
    mk = '{r, v, j, d, s, wv, wr, f, er, el};
  endfunction

  function automatic logic [N*RW-1:0] rdp(int a, int b, int c, int d);
    rdp = {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  function automatic logic [N*NR-1:0] rgp(logic [NR-1:0] a, b, c, d);
    rgp = {d, c, b, a};
  endfunction

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic drive(logic r, logic [N-1:0] v, j, logic [N*RW-1:0] d, logic [N*NR-1:0] s,
                       logic wv, logic [RW-1:0] wr, logic f);
    rst = r; valid = v; jump = j; rd = d; regs = s; wbv = wv; wbr = wr; fl = f;
  endtask

  bit ml [NR];
  int mp;

  task automatic model_step(output logic [N-1:0] er, output logic [NR-1:0] el);
    int g;
    g = -1;
    er = '0;
    for (int i = 0; i < N && !rst; i++) begin
      int k;
      bit ok;
      int dst;
      k = (mp + i) % N;
      dst = int'(rd[k*RW +: RW]);
      ok = valid[k];
      for (int r = 0; r < NR; r++)
        if (ml[r] && (regs[k*NR + r] || (dst != 0 && r == dst))) ok = 0;
      if (ok && g < 0) g = k;
    end
    if (g >= 0) er[g] = 1'b1;
    if (rst) begin
      foreach (ml[r]) ml[r] = 0;
      mp = 0;
    end else begin
      if (fl) foreach (ml[r]) ml[r] = 0;
      else if (wbv) ml[wbr] = 0;
      if (g >= 0) begin
        if (jump[g]) foreach (ml[r]) ml[r] = 1;
        else if (rd[g*RW +: RW] != 0) ml[rd[g*RW +: RW]] = 1;
        mp = (g + 1) % N;
      end
    end
    for (int r = 0; r < NR; r++) el[r] = ml[r];
  endtask

  task automatic check_cycle(string tag, logic [N-1:0] er, logic [NR-1:0] el);
    logic [QW-1:0] ei;
    ei = '0;
    for (int k = 0; k < N; k++) if (er[k]) ei = QW'(k);
    @(negedge clk);
    chk({tag, " ready"}, 64'(ready), 64'(er));
    chk({tag, " gnt_valid"}, 64'(gvalid), 64'(|er));
    chk({tag, " gnt_idx"}, 64'(gidx), 64'(ei));
    @(posedge clk);
    #1;
    chk({tag, " locks"}, 64'(locks), 64'(el));
  endtask

  vec_t t [19];

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    t[0]  = mk(1, 4'b0000, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
    t[1]  = mk(0, 4'b0001, 0, rdp(5,0,0,0), 0, 0, 0, 0, 4'b0001, 32'h20);
    t[2]  = mk(0, 4'b0010, 0, 0, rgp(0,32'h20,0,0), 1, 5, 0, 4'b0000, 0);
    t[3]  = mk(0, 4'b0010, 0, 0, rgp(0,32'h20,0,0), 0, 0, 0, 4'b0010, 0);
    t[4]  = mk(1, 4'b1111, 0, rdp(1,2,3,4), 0, 0, 0, 0, 4'b0000, 0);
    t[5]  = mk(0, 4'b1111, 0, rdp(1,2,3,4), 0, 0, 0, 0, 4'b0001, 32'h02);
    t[6]  = mk(0, 4'b1110, 0, rdp(1,2,3,4), 0, 0, 0, 0, 4'b0010, 32'h06);
    t[7]  = mk(0, 4'b1100, 0, rdp(1,2,3,4), 0, 0, 0, 0, 4'b0100, 32'h0E);
    t[8]  = mk(0, 4'b1000, 0, rdp(1,2,3,4), 0, 0, 0, 0, 4'b1000, 32'h1E);
    t[9]  = mk(0, 4'b0100, 4'b0100, 0, 0, 0, 0, 0, 4'b0100, '1);
    t[10] = mk(0, 4'b1000, 0, 0, rgp(0,0,0,32'h8), 0, 0, 0, 4'b0000, '1);
    t[11] = mk(0, 4'b1000, 0, 0, rgp(0,0,0,32'h8), 0, 0, 1, 4'b0000, 0);
    t[12] = mk(0, 4'b1000, 0, 0, rgp(0,0,0,32'h8), 0, 0, 0, 4'b1000, 0);
    t[13] = mk(0, 4'b0001, 0, rdp(7,0,0,0), 0, 1, 7, 0, 4'b0001, 32'h80);
    t[14] = mk(0, 4'b0010, 0, 0, 0, 0, 0, 0, 4'b0010, 32'h80);
    t[15] = mk(0, 4'b0100, 4'b0100, 0, 0, 0, 0, 0, 4'b0100, '1);
    t[16] = mk(0, 4'b0011, 0, rdp(5,0,0,0), 0, 0, 0, 0, 4'b0010, '1);
    t[17] = mk(1, 4'b0100, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
    t[18] = mk(0, 4'b1111, 0, 0, 0, 0, 0, 0, 4'b0001, 0);
    @(posedge clk);
    #1;
    foreach (t[i]) begin
      drive(t[i].r, t[i].v, t[i].j, t[i].d, t[i].s, t[i].wv, t[i].wr, t[i].f);
      check_cycle($sformatf("vec%0d", i), t[i].e_ready, t[i].e_locks);
    end
    foreach (ml[r]) ml[r] = 0;
    mp = 0;
    for (int c = 0; c < 500; c++) begin
      logic [N-1:0] er, vj;
      logic [NR-1:0] el;
      logic [N*RW-1:0] d;
      logic [N*NR-1:0] s;
      for (int k = 0; k < N; k++) begin
        vj[k] = ($urandom_range(15) == 0);
        d[k*RW +: RW] = RW'($urandom_range(7));
        s[k*NR +: NR] = NR'($urandom & $urandom & 32'hFF);
      end
      drive(c == 0 || $urandom_range(39) == 0, N'($urandom), vj, d, s,
            $urandom_range(1) == 1, RW'($urandom_range(7)), $urandom_range(14) == 0);
      model_step(er, el);
      check_cycle($sformatf("rnd%0d", c), er, el);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
